// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and sizing helpers for the neuron_acc_relu datapath.
package neuron_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    // Accumulator width that cannot overflow: NUM_IN full products plus an
    // optional 2*WIDTH bias, with one extra bit of headroom for the sign.
    function automatic int acc_width(input int width, input int num_in);
        return 2 * width + $clog2(num_in) + 1;
    endfunction

endpackage

// File: rtl/relu_sat.sv
// relu_sat: combinational ReLU, arithmetic right shift and unsigned saturation
// of a signed accumulator value down to a WIDTH-bit activation.
module relu_sat
    import neuron_pkg::*;
#(
    parameter int ACC_W     = 20,
    parameter int WIDTH     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic [ACC_W-1:0] sum,
    output logic [WIDTH-1:0] act
);

    logic signed [ACC_W-1:0] shifted;
    logic                    non_pos;
    logic                    too_big;

    assign non_pos = sum[ACC_W-1] || (sum == '0);
    assign shifted = $signed(sum) >>> OUT_SHIFT;
    // Only reached for positive sums, so any set bit above WIDTH means overflow.
    assign too_big = |shifted[ACC_W-1:WIDTH];

    // Clamp: non-positive sums give 0, large positives pin at all-ones.
    always_comb begin
        act = shifted[WIDTH-1:0];
        if (non_pos) begin
            act = '0;
        end else if (too_big) begin
            act = '1;
        end
    end

endmodule

// File: rtl/neuron_acc_relu.sv
// neuron_acc_relu: streams NUM_IN signed (w, x) pairs, accumulates their
// products at full precision, then presents one ReLU/shift/saturated
// activation on a valid/ready output port.
// Optional feature macro: NEURON_BIAS_EN adds a signed bias port that seeds
// the accumulator on the first beat of each neuron.
//
//   state | meaning
//   S_ACC | accepting w/x beats, in_ready=1
//   S_OUT | holding the activation, out_valid=1 until out_ready
module neuron_acc_relu
    import neuron_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 4,
    parameter int OUT_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   w,
    input  logic [WIDTH-1:0]   x,
`ifdef NEURON_BIAS_EN
    input  logic [2*WIDTH-1:0] bias,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out
);

    localparam int ACC_W = acc_width(WIDTH, NUM_IN);
    localparam int CNT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_IN - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_base;
    logic [ACC_W-1:0]        acc_next;
    logic signed [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]        prod_ext;
    logic [WIDTH-1:0]        act;
    logic                    accept;
    logic                    last_beat;

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt == CNT_LAST);

    assign prod     = $signed(w) * $signed(x);
    assign prod_ext = {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};

`ifdef NEURON_BIAS_EN
    assign acc_base = (cnt == '0) ? {{(ACC_W - 2*WIDTH){bias[2*WIDTH-1]}}, bias} : acc;
`else
    assign acc_base = (cnt == '0) ? '0 : acc;
`endif
    assign acc_next = acc_base + prod_ext;

    // The activation is taken from the sum including the final beat, so out
    // is ready in the same edge that enters S_OUT.
    relu_sat #(
        .ACC_W    (ACC_W),
        .WIDTH    (WIDTH),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_relu_sat (
        .sum(acc_next),
        .act(act)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave S_ACC on the last beat, leave S_OUT on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC: if (last_beat) state_d = S_OUT;
            S_OUT: if (out_ready) state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    // Beat counter and accumulator advance on every accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        end
    end

    // Registered activation, held stable while S_OUT waits for out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (last_beat) begin
            out <= act;
        end
    end

endmodule

// File: doc/neuron_acc_relu.md
# neuron_acc_relu

Sequential single-neuron datapath. It accepts NUM_IN signed (weight, input) pairs over a valid/ready stream and accumulates their products in a full-precision accumulator. It then applies ReLU with a right shift and saturation, and presents one unsigned WIDTH-bit activation on an output valid/ready port. It is the successor to the fixed 8-bit free-running MAC: it adds a bounded dot-product length, handshakes, overflow-free accumulation and output scaling. It sits between the weight/activation fetch logic and the next layer's input buffer.

## Interface
- WIDTH, 8, bit width of w, x and out
- NUM_IN, 4, products per neuron result (>= 1)
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  w/x beat valid
- in_ready  out  1  block can accept a beat
- w  in  WIDTH  signed weight
- x  in  WIDTH  signed input
- bias  in  2*WIDTH  signed bias, only with NEURON_BIAS_EN
- out_valid  out  1  activation valid
- out_ready  in  1  downstream accepts activation
- out  out  WIDTH  unsigned activation

## Operation
- Reset: rst is asynchronous, active-low, on clk.
- Accumulator width: ACC_W = 2*WIDTH + $clog2(NUM_IN) + 1. Never overflows, including the bias term.
- Products: the full signed 2*WIDTH product of w and x, sign-extended to ACC_W.
- FSM has two states, S_ACC and S_OUT. Reset state is S_ACC.
- S_ACC:
  - in_ready=1, out_valid=0.
  - On an accepted beat (in_valid && in_ready): acc <= (cnt==0 ? 0 : acc) + prod, and cnt increments.
  - On the beat where cnt==NUM_IN-1: cnt <= 0, the registered result is computed from the final sum, and the state moves to S_OUT.
- S_OUT:
  - in_ready=0, out_valid=1, and out is held stable.
  - On out_valid && out_ready: state returns to S_ACC.
- Activation function:
  - If the final sum <= 0, out = 0.
  - Otherwise s = sum >>> OUT_SHIFT, and out = (s > 2^WIDTH-1) ? 2^WIDTH-1 : s[WIDTH-1:0].
- in_valid is ignored while in S_OUT. The upstream holds the beat until in_ready returns.
- Reset mid-operation: all partial state is discarded. The next accepted beat is treated as the first of a new neuron.

## Timing
- Reset values: in_ready=1, out_valid=0, out=0, cnt=0, acc=0, state S_ACC.
- Latency: out_valid rises on the clock edge that accepts the NUM_IN-th beat, so it is visible the following cycle.
- Throughput: NUM_IN+1 cycles per result when in_valid and out_ready are held high. The handshake cycle in S_OUT accepts no input beat.
- out and out_valid are registered outputs with no combinational path from the inputs.
- in_ready is a function of the state register only.
- out_ready held low keeps S_OUT, out, and out_valid=1 indefinitely.
- NUM_IN=1: every accepted beat produces a result.

## Configuration
- Macro: NEURON_BIAS_EN.
- When defined:
  - The bias port exists.
  - bias is sampled on the first beat (cnt==0) and added, sign-extended, into the accumulator in that same cycle: acc <= bias + prod.
- When undefined:
  - The bias port is absent and the accumulator starts from 0.
  - Behaviour is otherwise identical.

## Structure
- Package neuron_pkg holds:
  - the state typedef (S_ACC, S_OUT);
  - the function acc_width(WIDTH, NUM_IN) returning ACC_W.
- Sub-module relu_sat: combinational, parameters ACC_W, WIDTH, OUT_SHIFT. It performs the sign check, shift and saturation. It is instantiated once, and its output is registered into out.
- Top level holds the FSM, the counter, the accumulator and the multiplier.

## Test plan
All scenarios use WIDTH=8, NUM_IN=4, OUT_SHIFT=0 unless stated.
- Basic: 4 beats of w=3, x=5, out_ready=1 -> out_valid one cycle after the 4th beat, out=60, in_ready low exactly 1 cycle.
- Negative: 4 beats of w=-128, x=127 -> out=0.
- Saturation: 4 beats of w=127, x=127 (sum 64516) -> out=255.
- Shift: the same beats with OUT_SHIFT=8 -> out=252.
- Backpressure: out_ready low for 3 cycles after out_valid -> out=60 stable, in_ready=0 and in_valid ignored. Then on the out_ready handshake -> in_ready=1 the next cycle.
- Reset mid-operation: 2 beats of w=3, x=5, then rst low for 1 cycle -> out_valid=0, in_ready=1. Then 4 beats of w=1, x=2 -> out=8.
- Bias, with NEURON_BIAS_EN: bias=-20 and 4 beats of w=3, x=5 -> out=40. With bias=-70 -> out=0.
